// File: rtl/m107_pkg.sv
// Shared types and widths for the m107 SDRAM access path.
// The arbiter pointer is 3 bits wide, so at most 8 requesters are supported.
package m107_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_t;

  localparam int SDR_ADDR_W = 25;
  localparam int SDR_DATA_W = 16;
  localparam int PTR_W      = 3;

endpackage

// File: rtl/sdr_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: requester 0 may preempt, otherwise scan from last+1.
// Zero latency; no backpressure of its own, the caller decides when to accept the winner.
module rr_pick
  import m107_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last,
  input  logic               prio0,
  output logic [PTR_W-1:0]   winner,
  output logic               any_vld
);

  logic [7:0]  req_pad;
  logic [31:0] idx;
  logic        found;

  assign req_pad = 8'(req);
  assign any_vld = |req;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    if (prio0 && req[0]) begin
      found = 1'b1;
    end
    // Offsets 1..NUM_REQ visit every index once, ending on last itself.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last) + 32'(off)) % 32'(NUM_REQ);
      if (!found && req_pad[idx[PTR_W-1:0]]) begin
        winner = idx[PTR_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdr_channel_arbiter.sv
// Shares one SDRAM channel among NUM_REQ requesters, one access outstanding; ack = rdy + 1 cycle.
// Backpressure: sdr_req and the sdr_* fields are held until sdr_rdy; requests wait while not IDLE.
module sdr_channel_arbiter
  import m107_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SDR_ADDR_W,
  parameter int DATA_W  = SDR_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  loading,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_be,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  sdr_req,
  output logic                  sdr_we,
  output logic [ADDR_W-1:0]     sdr_addr,
  output logic [DATA_W-1:0]     sdr_data,
  output logic [1:0]            sdr_be,
  input  logic                  sdr_rdy,
  input  logic [DATA_W-1:0]     sdr_dout
);

  arb_state_t      state, state_nxt;
  logic [PTR_W-1:0] grant, last_grant, winner;
  logic             any_vld;
  logic [7:0]       we_pad;

  assign we_pad = 8'(req_we);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req     (req),
    .last    (last_grant),
    .prio0   (loading),
    .winner  (winner),
    .any_vld (any_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (any_vld) state_nxt = ARB_BUSY;
      ARB_BUSY: if (sdr_rdy) state_nxt = ARB_DONE;
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= '0;
      last_grant <= PTR_W'(NUM_REQ - 1);
      ack        <= '0;
      rdata      <= '0;
      sdr_req    <= 1'b0;
      sdr_we     <= 1'b0;
      sdr_addr   <= '0;
      sdr_data   <= '0;
      sdr_be     <= '0;
    end else begin
      ack <= '0;
      case (state)
        ARB_IDLE: begin
          if (any_vld) begin
            grant      <= winner;
            last_grant <= winner;
            sdr_req    <= 1'b1;
            sdr_we     <= we_pad[winner];
            sdr_addr   <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            sdr_data   <= req_data[int'(winner)*DATA_W +: DATA_W];
            sdr_be     <= req_be[int'(winner)*2 +: 2];
          end
        end
        ARB_BUSY: begin
          if (sdr_rdy) begin
            sdr_req <= 1'b0;
            ack     <= NUM_REQ'(1) << grant;
            if (!sdr_we) rdata <= sdr_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_channel_arbiter.sv
// Directed bench for sdr_channel_arbiter: priority, rotation, timing and reset behaviour.
module tb_sdr_channel_arbiter;

  localparam int N  = 4;
  localparam int AW = 25;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            loading = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*2-1:0]  req_be = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            sdr_req, sdr_we;
  logic [AW-1:0]   sdr_addr;
  logic [DW-1:0]   sdr_data;
  logic [1:0]      sdr_be;
  logic            sdr_rdy;
  logic [DW-1:0]   sdr_dout = '0;

  logic auto_rdy = 1'b0;
  logic auto_q   = 1'b0;
  logic man_rdy  = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  assign sdr_rdy = auto_q | man_rdy;

  sdr_channel_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .loading  (loading),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_be   (req_be),
    .ack      (ack),
    .rdata    (rdata),
    .sdr_req  (sdr_req),
    .sdr_we   (sdr_we),
    .sdr_addr (sdr_addr),
    .sdr_data (sdr_data),
    .sdr_be   (sdr_be),
    .sdr_rdy  (sdr_rdy),
    .sdr_dout (sdr_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller that answers in the same cycle sdr_req is seen high.
  always @(posedge clk) begin
    #1;
    auto_q = auto_rdy & sdr_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (sdr_req !== 1'b0) begin tests_failed++; $display("FAIL reset_sdr_req got %0b want 0", sdr_req); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack got %b want 0000", ack); end
    tests_run++; if (rdata !== 16'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    tests_run++; if (sdr_addr !== 25'h0 || sdr_we !== 1'b0 || sdr_be !== 2'b00)
      begin tests_failed++; $display("FAIL reset_sdr_fields got addr=%h we=%0b be=%b want 0", sdr_addr, sdr_we, sdr_be); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [6];
    int n = 0;
    int last_cyc = 0;
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    sdr_dout = 16'h1111;
    loading  = 1'b0;
    auto_rdy = 1'b1;
    req      = 4'b1110;
    for (int t = 0; t < 40 && n < 6; t++) begin
      tick();
      if (ack !== 4'b0000) begin
        tests_run++; if (ack !== exp_seq[n]) begin tests_failed++; $display("FAIL rr_order[%0d] got %b want %b", n, ack, exp_seq[n]); end
        if (n > 0) begin
          tests_run++; if (cyc - last_cyc !== 3) begin tests_failed++; $display("FAIL rr_spacing[%0d] got %0d want 3", n, cyc - last_cyc); end
        end
        last_cyc = cyc;
        n++;
        if (n == 6) req = '0;
      end
    end
    tests_run++; if (n !== 6) begin tests_failed++; $display("FAIL rr_ack_count got %0d want 6", n); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_loader_priority();
    int n = 0;
    loading  = 1'b1;
    auto_rdy = 1'b1;
    req      = 4'b1111;
    for (int t = 0; t < 40 && n < 4; t++) begin
      tick();
      if (ack !== 4'b0000) begin
        if (n < 3) begin
          tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL loader_grant[%0d] got %b want 0001", n, ack); end
          if (n == 2) loading = 1'b0;
        end else begin
          tests_run++; if (ack !== 4'b0010) begin tests_failed++; $display("FAIL loader_release_grant got %b want 0010", ack); end
          req = '0;
        end
        n++;
      end
    end
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL loader_ack_count got %0d want 4", n); end
    req = '0;
    auto_rdy = 1'b0;
    tick(); tick();
  endtask

  task automatic test_single_read();
    req_addr[2*AW +: AW] = 25'h0012345;
    req_we[2] = 1'b0;
    req[2] = 1'b1;
    tick();
    tests_run++; if (sdr_req !== 1'b1) begin tests_failed++; $display("FAIL read_sdr_req_latency got %0b want 1", sdr_req); end
    tests_run++; if (sdr_addr !== 25'h0012345) begin tests_failed++; $display("FAIL read_addr got %h want 0012345", sdr_addr); end
    tests_run++; if (sdr_we !== 1'b0) begin tests_failed++; $display("FAIL read_we got %0b want 0", sdr_we); end
    for (int t = 0; t < 3; t++) begin
      tick();
      tests_run++; if (sdr_req !== 1'b1 || ack !== 4'b0000)
        begin tests_failed++; $display("FAIL read_hold[%0d] got sdr_req=%0b ack=%b want 1/0000", t, sdr_req, ack); end
    end
    sdr_dout = 16'hBEEF;
    man_rdy  = 1'b1;
    tick();
    man_rdy = 1'b0;
    req = '0;
    tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL read_ack got %b want 0100", ack); end
    tests_run++; if (rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL read_rdata got %h want beef", rdata); end
    tests_run++; if (sdr_req !== 1'b0) begin tests_failed++; $display("FAIL read_sdr_req_drop got %0b want 0", sdr_req); end
    tick();
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL read_ack_one_cycle got %b want 0000", ack); end
    tick();
  endtask

  task automatic test_write();
    req_addr[0 +: AW] = 25'h1ABCDEF;
    req_data[0 +: DW] = 16'h5A5A;
    req_be[0 +: 2]    = 2'b01;
    req_we[0] = 1'b1;
    req[0] = 1'b1;
    tick();
    tests_run++; if (sdr_req !== 1'b1 || sdr_we !== 1'b1) begin tests_failed++; $display("FAIL write_req_we got req=%0b we=%0b want 1/1", sdr_req, sdr_we); end
    tests_run++; if (sdr_data !== 16'h5A5A) begin tests_failed++; $display("FAIL write_data got %h want 5a5a", sdr_data); end
    tests_run++; if (sdr_be !== 2'b01) begin tests_failed++; $display("FAIL write_be got %b want 01", sdr_be); end
    tests_run++; if (sdr_addr !== 25'h1ABCDEF) begin tests_failed++; $display("FAIL write_addr got %h want 1abcdef", sdr_addr); end
    sdr_dout = 16'h1234;
    man_rdy  = 1'b1;
    tick();
    man_rdy = 1'b0;
    req = '0;
    req_we[0] = 1'b0;
    tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL write_ack got %b want 0001", ack); end
    tests_run++; if (rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL write_rdata_kept got %h want beef", rdata); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_op();
    req_addr[1*AW +: AW] = 25'h0000ABC;
    req[1] = 1'b1;
    tick();
    tests_run++; if (sdr_req !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_busy got %0b want 1", sdr_req); end
    reset_n = 1'b0;
    #1;
    tests_run++; if (sdr_req !== 1'b0 || ack !== 4'b0000)
      begin tests_failed++; $display("FAIL rst_mid_drop got sdr_req=%0b ack=%b want 0/0000", sdr_req, ack); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    tests_run++; if (sdr_req !== 1'b1 || sdr_addr !== 25'h0000ABC)
      begin tests_failed++; $display("FAIL rst_regrant got sdr_req=%0b addr=%h want 1/0000abc", sdr_req, sdr_addr); end
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    req = '0;
    tests_run++; if (ack !== 4'b0010) begin tests_failed++; $display("FAIL rst_regrant_ack got %b want 0010", ack); end
    tick(); tick();
  endtask

  task automatic test_spurious_withdrawn();
    man_rdy = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      tests_run++; if (ack !== 4'b0000 || sdr_req !== 1'b0)
        begin tests_failed++; $display("FAIL spurious_rdy[%0d] got ack=%b sdr_req=%0b want 0000/0", t, ack, sdr_req); end
    end
    man_rdy = 1'b0;
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    tests_run++; if (sdr_req !== 1'b1) begin tests_failed++; $display("FAIL withdrawn_busy got %0b want 1", sdr_req); end
    tick();
    tests_run++; if (sdr_req !== 1'b1) begin tests_failed++; $display("FAIL withdrawn_hold got %0b want 1", sdr_req); end
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    tests_run++; if (ack !== 4'b1000) begin tests_failed++; $display("FAIL withdrawn_ack got %b want 1000", ack); end
    tick();
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL withdrawn_ack_once got %b want 0000", ack); end
    tick();
    tests_run++; if (sdr_req !== 1'b0 || ack !== 4'b0000)
      begin tests_failed++; $display("FAIL withdrawn_no_regrant got sdr_req=%0b ack=%b want 0/0000", sdr_req, ack); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_loader_priority();
    test_single_read();
    test_write();
    test_reset_mid_op();
    test_spurious_withdrawn();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
